// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch controller
// (master) and the instruction memory (slave).
interface if_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: issues word fetches to instruction memory,
// presents one fetched instruction per cycle to decode, buffers one word in a
// skid register while decode stalls, and handles branch redirects including
// redirects that arrive while a memory request is still outstanding.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch,
  input  logic [31:0]           pc_branch,
  input  logic                  stall_D,
  if_fetch_ctrl_if.master       imem,
  output logic                  valid_F,
  output logic [31:0]           Instruction_F,
  output logic [31:0]           Pc_F,
  output logic [31:0]           PcPlus4_F
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;           // address currently presented to memory
  logic [31:0] redirect_pc;  // branch target parked while DROP waits for ack
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic [31:0] branch_tgt;
  logic [31:0] pc_next_seq;
  logic        slot_free;

  assign branch_tgt  = {pc_branch[31:2], 2'b00};
  assign pc_next_seq = pc + 32'd4;
  assign slot_free   = !valid_F || !stall_D;

  // Request is decoded from state so it stays up, at a fixed address, until ack.
  assign imem.imem_req  = (state == FETCH) || (state == DROP);
  assign imem.imem_addr = pc;

  // Fetch FSM with registered F-stage outputs and skid buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      redirect_pc   <= 32'h0000_0000;
      skid_instr    <= 32'h0000_0000;
      skid_pc       <= 32'h0000_0000;
      valid_F       <= 1'b0;
      Instruction_F <= 32'h0000_0000;
      Pc_F          <= 32'h0000_0000;
      PcPlus4_F     <= 32'h0000_0000;
    end else begin
      // Decode consumed the current word; a load below may refill the slot.
      if (valid_F && !stall_D) begin
        valid_F <= 1'b0;
      end

      case (state)
        IDLE: begin
          state <= FETCH;
          if (branch) begin
            pc <= branch_tgt;
          end
        end

        FETCH: begin
          if (branch) begin
            valid_F    <= 1'b0;
            skid_instr <= 32'h0000_0000;
            skid_pc    <= 32'h0000_0000;
            if (imem.imem_ack) begin
              // Returned word belongs to the old path: drop it, refetch now.
              pc    <= branch_tgt;
              state <= FETCH;
            end else begin
              // Request must not be withdrawn; wait for it in DROP.
              redirect_pc <= branch_tgt;
              state       <= DROP;
            end
          end else if (imem.imem_ack) begin
            pc <= pc_next_seq;
            if (slot_free) begin
              valid_F       <= 1'b1;
              Instruction_F <= imem.imem_rdata;
              Pc_F          <= pc;
              PcPlus4_F     <= pc_next_seq;
              state         <= FETCH;
            end else begin
              skid_instr <= imem.imem_rdata;
              skid_pc    <= pc;
              state      <= HOLD;
            end
          end else begin
            state <= FETCH;
          end
        end

        HOLD: begin
          if (branch) begin
            pc         <= branch_tgt;
            valid_F    <= 1'b0;
            skid_instr <= 32'h0000_0000;
            skid_pc    <= 32'h0000_0000;
            state      <= FETCH;
          end else if (slot_free) begin
            valid_F       <= 1'b1;
            Instruction_F <= skid_instr;
            Pc_F          <= skid_pc;
            PcPlus4_F     <= skid_pc + 32'd4;
            state         <= FETCH;
          end else begin
            state <= HOLD;
          end
        end

        DROP: begin
          if (branch) begin
            valid_F <= 1'b0;
          end
          if (imem.imem_ack) begin
            // Old-path data discarded; the most recent redirect wins.
            pc    <= branch ? branch_tgt : redirect_pc;
            state <= FETCH;
          end else begin
            if (branch) begin
              redirect_pc <= branch_tgt;
            end
            state <= DROP;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_if_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic [31:0] pc_branch;
  logic        stall_D;
  logic        valid_F;
  logic [31:0] Instruction_F;
  logic [31:0] Pc_F;
  logic [31:0] PcPlus4_F;

  int checks = 0;
  int errors = 0;

  if_fetch_ctrl_if imem_bus ();

  if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch        (branch),
    .pc_branch     (pc_branch),
    .stall_D       (stall_D),
    .imem          (imem_bus.master),
    .valid_F       (valid_F),
    .Instruction_F (Instruction_F),
    .Pc_F          (Pc_F),
    .PcPlus4_F     (PcPlus4_F)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // started: first edge after reset seen; addr: address being requested;
  // discard/redirect: an old-path request still in flight and where to go
  // afterwards; held: words fetched but not yet handed to decode.
  logic        m_started;
  logic [31:0] m_addr;
  logic        m_discard;
  logic [31:0] m_redirect;
  logic [63:0] m_held[$];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [31:0] m_pc4;

  task automatic model_reset();
    m_started  = 1'b0;
    m_addr     = 32'h0000_0000;
    m_discard  = 1'b0;
    m_redirect = 32'h0000_0000;
    m_held.delete();
    m_valid    = 1'b0;
    m_instr    = 32'h0000_0000;
    m_pc       = 32'h0000_0000;
    m_pc4      = 32'h0000_0000;
  endtask

  function automatic logic model_req();
    return m_started && (m_held.size() == 0);
  endfunction

  task automatic deliver(input logic [31:0] instr, input logic [31:0] pc);
    m_valid = 1'b1;
    m_instr = instr;
    m_pc    = pc;
    m_pc4   = pc + 32'd4;
  endtask

  task automatic model_step(input logic br, input logic [31:0] tgt_in, input logic stl,
                            input logic ack, input logic [31:0] rd);
    logic [31:0] tgt;
    logic        req;
    logic        ack_seen;
    logic        free;
    tgt      = tgt_in & 32'hFFFF_FFFC;
    req      = model_req();
    ack_seen = req && ack;
    free     = !m_valid || !stl;
    if (m_valid && !stl) m_valid = 1'b0;
    if (!m_started) begin
      m_started = 1'b1;
      if (br) m_addr = tgt;
    end else if (br) begin
      m_valid = 1'b0;
      m_held.delete();
      if (req && !ack) begin
        m_discard  = 1'b1;
        m_redirect = tgt;
      end else begin
        m_discard = 1'b0;
        m_addr    = tgt;
      end
    end else if (m_discard) begin
      if (ack_seen) begin
        m_discard = 1'b0;
        m_addr    = m_redirect;
      end
    end else if (m_held.size() != 0) begin
      if (free) begin
        deliver(m_held[0][63:32], m_held[0][31:0]);
        m_held.delete();
      end
    end else if (ack_seen) begin
      if (free) deliver(rd, m_addr);
      else m_held.push_back({rd, m_addr});
      m_addr = m_addr + 32'd4;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, model_req()});
    check("imem_addr", imem_bus.imem_addr, m_addr);
    check("valid_F", {31'd0, valid_F}, {31'd0, m_valid});
    check("Instruction_F", Instruction_F, m_instr);
    check("Pc_F", Pc_F, m_pc);
    check("PcPlus4_F", PcPlus4_F, m_pc4);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(branch, pc_branch, stall_D, imem_bus.imem_ack, imem_bus.imem_rdata);
    #1;
    compare_all();
  endtask

  task automatic async_reset_pulse();
    #3 rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("rst_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    check("rst_valid_low", {31'd0, valid_F}, 32'd0);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    branch = 1'b0;
    pc_branch = 32'h0000_0000;
    stall_D = 1'b0;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = 32'h0000_0000;
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Streaming with single-cycle ack and address-derived data.
    imem_bus.imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      imem_bus.imem_rdata = imem_bus.imem_addr ^ 32'hA5A5_0000;
      step();
      if (i == 0) check("first_addr", imem_bus.imem_addr, 32'h0000_0000);
      if (i == 1) check("first_valid", {31'd0, valid_F}, 32'd1);
    end
    check("stream_pc", Pc_F, 32'h0000_0010);
    check("stream_pc4", PcPlus4_F, 32'h0000_0014);

    // Decode stall for three cycles: one word parks in the skid buffer.
    stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_bus.imem_rdata = imem_bus.imem_addr ^ 32'hA5A5_0000;
      step();
    end
    check("stall_pc_frozen", Pc_F, 32'h0000_0010);
    check("stall_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    stall_D = 1'b0;
    step();
    check("skid_out_pc", Pc_F, 32'h0000_0014);
    check("skid_out_instr", Instruction_F, 32'hA5A5_0014);
    check("resume_addr", imem_bus.imem_addr, 32'h0000_0018);

    // Three-cycle ack latency with a redirect in the first wait cycle.
    imem_bus.imem_ack = 1'b0;
    branch = 1'b1;
    pc_branch = 32'h0f0f_0f00;
    step();
    branch = 1'b0;
    check("drop_addr_held", imem_bus.imem_addr, 32'h0000_0018);
    check("drop_valid", {31'd0, valid_F}, 32'd0);
    step();
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    check("redirect_addr", imem_bus.imem_addr, 32'h0f0f_0f00);
    check("drop_data_discarded", {31'd0, valid_F}, 32'd0);

    // Branch together with ack on an unaligned target.
    branch = 1'b1;
    pc_branch = 32'h0000_0103;
    step();
    check("br_ack_valid", {31'd0, valid_F}, 32'd0);
    check("br_ack_addr", imem_bus.imem_addr, 32'h0000_0100);

    // Address wrap at the top of the address space.
    pc_branch = 32'hFFFF_FFFC;
    step();
    branch = 1'b0;
    imem_bus.imem_rdata = 32'h1234_5678;
    step();
    check("wrap_pc", Pc_F, 32'hFFFF_FFFC);
    check("wrap_pc4", PcPlus4_F, 32'h0000_0000);
    check("wrap_addr", imem_bus.imem_addr, 32'h0000_0000);

    // Asynchronous reset during an outstanding request, then a late ack.
    stall_D = 1'b1;
    imem_bus.imem_ack = 1'b0;
    step();
    async_reset_pulse();
    stall_D = 1'b0;
    imem_bus.imem_ack = 1'b1;
    step();
    check("post_rst_addr", imem_bus.imem_addr, 32'h0000_0000);
    check("late_ack_ignored", {31'd0, valid_F}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      branch = ($urandom_range(0, 99) < 8);
      pc_branch = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      stall_D = ($urandom_range(0, 99) < 35);
      imem_bus.imem_ack = ($urandom_range(0, 99) < 55);
      imem_bus.imem_rdata = $urandom;
      step();
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on run time in case the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
